// File: rtl/reg_file_param.sv
// Parametrised register file: NUM_RD combinational read ports, one synchronous write port, and a sequential bulk-clear engine.
// Optional feature macro REGFILE_BYPASS_EN: forwards the pending write data to matching read ports before the commit.
`timescale 1ns/1ps

// state       | meaning
// ST_IDLE     | normal operation; writes accepted; CLEAR starts a sweep
// ST_CLEARING | zeroing one register per cycle at ptr_q; writes rejected
module reg_file_param #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 3,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 0,
   parameter int RD_DLY   = 2,
   parameter int WR_DLY   = 1
) (
   input  logic                       CLK,
   input  logic                       RESET_N,
   input  logic [DATA_W-1:0]          IN,
   input  logic [ADDR_W-1:0]          INADDRESS,
   input  logic                       WRITE,
   input  logic [NUM_RD*ADDR_W-1:0]   RDADDR,
   output logic [NUM_RD*DATA_W-1:0]   RDDATA,
   input  logic                       CLEAR,
   output logic                       BUSY,
   output logic                       WR_REJ
);

   localparam int                NUM_REGS = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_REGS - 1);
   localparam bit                ZERO_EN  = (ZERO_REG != 0);

   // RD_DLY/WR_DLY only describe the behavioural timing model; the RTL itself is zero-delay.
   if (NUM_RD < 1 || NUM_RD > 4 || RD_DLY < 0 || WR_DLY < 0) begin : g_param_err
      $error("reg_file_param: unsupported parameter set");
   end

   typedef enum logic {
      ST_IDLE,
      ST_CLEARING
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [ADDR_W-1:0]   ptr_q;
   logic [ADDR_W-1:0]   ptr_d;
   logic                busy;
   logic                clr_en;
   logic                wr_hit_zero;
   logic                wr_en;
   logic                wr_rej_q;
   logic [DATA_W-1:0]   regs [NUM_REGS];

   assign busy        = (state_q == ST_CLEARING);
   assign clr_en      = busy;
   assign wr_hit_zero = ZERO_EN && (INADDRESS == '0);
   assign wr_en       = WRITE && !busy && !wr_hit_zero;

   assign BUSY   = busy;
   assign WR_REJ = wr_rej_q;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         wr_rej_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         wr_rej_q <= WRITE && busy;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (CLEAR) begin
               state_d = ST_CLEARING;
               ptr_d   = '0;
            end
         end
         ST_CLEARING: begin
            // CLEAR is deliberately not looked at here: a sweep in progress never restarts.
            if (ptr_q == LAST_PTR) begin
               state_d = ST_IDLE;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            ptr_d   = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (clr_en) begin
         regs[ptr_q] <= '0;
      end else if (wr_en) begin
         regs[INADDRESS] <= IN;
      end
   end

`ifdef REGFILE_BYPASS_EN
   logic wr_fwd;
   assign wr_fwd = WRITE && !busy;
`endif

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd;

      assign ra = RDADDR[k*ADDR_W +: ADDR_W];

      always_comb begin
         rd = regs[ra];
`ifdef REGFILE_BYPASS_EN
         if (wr_fwd && (ra == INADDRESS)) begin
            rd = IN;
         end
`endif
         // Applied last so a forwarded write to register 0 can never leak through.
         if (ZERO_EN && (ra == '0)) begin
            rd = '0;
         end
      end

      assign RDDATA[k*DATA_W +: DATA_W] = rd;
   end

endmodule

// File: tb/tb_reg_file_param.sv
// Self-checking bench for reg_file_param: default 8x8 two-port file plus a ZERO_REG=1, 16-bit, three-port instance.
`timescale 1ns/1ps

module tb_reg_file_param;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        CLK;
   logic        RESET_N;

   logic [7:0]  in_a;
   logic [2:0]  inaddr_a;
   logic        write_a;
   logic [5:0]  rdaddr_a;
   logic [15:0] rddata_a;
   logic        clear_a;
   logic        busy_a;
   logic        rej_a;

   logic [15:0] in_z;
   logic [2:0]  inaddr_z;
   logic        write_z;
   logic [8:0]  rdaddr_z;
   logic [47:0] rddata_z;
   logic        clear_z;
   logic        busy_z;
   logic        rej_z;

   reg_file_param dut (
      .CLK       (CLK),
      .RESET_N   (RESET_N),
      .IN        (in_a),
      .INADDRESS (inaddr_a),
      .WRITE     (write_a),
      .RDADDR    (rdaddr_a),
      .RDDATA    (rddata_a),
      .CLEAR     (clear_a),
      .BUSY      (busy_a),
      .WR_REJ    (rej_a)
   );

   reg_file_param #(.DATA_W(16), .ADDR_W(3), .NUM_RD(3), .ZERO_REG(1)) dut_z (
      .CLK       (CLK),
      .RESET_N   (RESET_N),
      .IN        (in_z),
      .INADDRESS (inaddr_z),
      .WRITE     (write_z),
      .RDADDR    (rdaddr_z),
      .RDDATA    (rddata_z),
      .CLEAR     (clear_z),
      .BUSY      (busy_z),
      .WR_REJ    (rej_z)
   );

   // Rising edges at 10, 20, 30, ...
   initial begin
      CLK = 1'b1;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached before end of test");
      $fatal(1, "watchdog");
   end

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] mdl [8];

   typedef struct {
      logic [2:0] addr;
      logic [7:0] val;
      string      tag;
   } exp_t;

   exp_t exp_q[$];

   task automatic push_exp(input logic [2:0] a, input logic [7:0] v, input string tag);
      exp_t e;
      e.addr = a;
      e.val  = v;
      e.tag  = tag;
      exp_q.push_back(e);
   endtask

   task automatic push_all(input string tag);
      for (int i = 0; i < 8; i++) begin
         push_exp(3'(i), mdl[i], tag);
      end
   endtask

   // Scoreboard consumer: present each expected address on both ports and compare.
   task automatic drain_reads();
      exp_t e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         rdaddr_a = {e.addr, e.addr};
         #1;
         n_checks++;
         if (rddata_a[7:0] !== e.val) begin
            n_fail++;
            $display("FAIL %s port0 addr %0d: got %h expected %h", e.tag, e.addr, rddata_a[7:0], e.val);
         end
         n_checks++;
         if (rddata_a[15:8] !== e.val) begin
            n_fail++;
            $display("FAIL %s port1 addr %0d: got %h expected %h", e.tag, e.addr, rddata_a[15:8], e.val);
         end
      end
   endtask

   task automatic do_write(input logic [2:0] a, input logic [7:0] v);
      @(negedge CLK);
      write_a  = 1'b1;
      inaddr_a = a;
      in_a     = v;
      @(posedge CLK);
      #1;
      write_a = 1'b0;
      mdl[a]  = v;
   endtask

   task automatic test_reset();
      RESET_N  = 1'b0;
      in_a     = '0;
      inaddr_a = '0;
      write_a  = 1'b0;
      rdaddr_a = '0;
      clear_a  = 1'b0;
      in_z     = '0;
      inaddr_z = '0;
      write_z  = 1'b0;
      rdaddr_z = '0;
      clear_z  = 1'b0;
      for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
      repeat (2) @(posedge CLK);
      #3;
      n_checks++;
      if (busy_a !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_busy: got %b expected 0", busy_a);
      end
      n_checks++;
      if (rej_a !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_wr_rej: got %b expected 0", rej_a);
      end
      n_checks++;
      if (busy_z !== 1'b0 || rej_z !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_z_flags: got busy %b rej %b expected 0 0", busy_z, rej_z);
      end
      push_all("reset_held");
      drain_reads();
      @(negedge CLK);
      RESET_N = 1'b1;
      @(posedge CLK);
      #3;
      n_checks++;
      if (busy_a !== 1'b0 || rej_a !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release_flags: got busy %b rej %b expected 0 0", busy_a, rej_a);
      end
      push_all("reset_released");
      drain_reads();
   endtask

   task automatic test_write_read();
      logic [7:0] pre;
      @(negedge CLK);
      write_a  = 1'b1;
      inaddr_a = 3'd2;
      in_a     = 8'h1F;
      rdaddr_a = {3'd1, 3'd2};
      #2;
      pre = BYP ? 8'h1F : mdl[2];
      n_checks++;
      if (rddata_a[7:0] !== pre) begin
         n_fail++;
         $display("FAIL write_read_precommit: got %h expected %h", rddata_a[7:0], pre);
      end
      @(posedge CLK);
      #1;
      write_a = 1'b0;
      mdl[2]  = 8'h1F;
      #2;
      n_checks++;
      if (rddata_a[7:0] !== 8'h1F) begin
         n_fail++;
         $display("FAIL write_read_port0: got %h expected 1f", rddata_a[7:0]);
      end
      n_checks++;
      if (rddata_a[15:8] !== mdl[1]) begin
         n_fail++;
         $display("FAIL write_read_port1: got %h expected %h", rddata_a[15:8], mdl[1]);
      end
   endtask

   task automatic test_negedge();
      logic [7:0] pre;
      @(posedge CLK);
      #4;
      write_a  = 1'b1;
      inaddr_a = 3'd3;
      in_a     = 8'h0F;
      rdaddr_a = {3'd3, 3'd3};
      pre = BYP ? 8'h0F : mdl[3];
      @(negedge CLK);
      #1;
      n_checks++;
      if (rddata_a[7:0] !== pre) begin
         n_fail++;
         $display("FAIL negedge_after_fall: got %h expected %h", rddata_a[7:0], pre);
      end
      #3;
      n_checks++;
      if (rddata_a[15:8] !== pre) begin
         n_fail++;
         $display("FAIL negedge_before_rise: got %h expected %h", rddata_a[15:8], pre);
      end
      @(posedge CLK);
      #1;
      write_a = 1'b0;
      mdl[3]  = 8'h0F;
      #2;
      n_checks++;
      if (rddata_a[7:0] !== 8'h0F) begin
         n_fail++;
         $display("FAIL negedge_after_rise: got %h expected 0f", rddata_a[7:0]);
      end
   endtask

   task automatic test_clear();
      int busy_cycles;
      int rej_cycles;
      int rej_at;
      int n;
      for (int i = 0; i < 8; i++) begin
         do_write(3'(i), 8'(8'h11 * (i + 1)));
      end
      push_all("clear_load");
      drain_reads();
      @(negedge CLK);
      clear_a = 1'b1;
      @(posedge CLK);
      #1;
      clear_a = 1'b0;
      #2;
      busy_cycles = 0;
      rej_cycles  = 0;
      rej_at      = 0;
      n           = 1;
      while (busy_a === 1'b1 && n <= 20) begin
         busy_cycles++;
         @(negedge CLK);
         write_a  = (n == 3);
         inaddr_a = 3'd1;
         in_a     = 8'hA5;
         clear_a  = (n == 5);
         @(posedge CLK);
         #1;
         write_a = 1'b0;
         clear_a = 1'b0;
         #2;
         if (rej_a === 1'b1) begin
            rej_cycles++;
            rej_at = n;
         end
         n++;
      end
      n_checks++;
      if (busy_cycles != 8) begin
         n_fail++;
         $display("FAIL clear_busy_cycles: got %0d expected 8", busy_cycles);
      end
      n_checks++;
      if (rej_cycles != 1 || rej_at != 3) begin
         n_fail++;
         $display("FAIL clear_wr_rej: got %0d pulses at cycle %0d expected 1 at cycle 3", rej_cycles, rej_at);
      end
      for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
      push_all("clear_result");
      drain_reads();
   endtask

   task automatic test_clear_and_write();
      int n;
      @(negedge CLK);
      clear_a  = 1'b1;
      write_a  = 1'b1;
      inaddr_a = 3'd6;
      in_a     = 8'h3C;
      rdaddr_a = {3'd6, 3'd6};
      @(posedge CLK);
      #1;
      clear_a = 1'b0;
      write_a = 1'b0;
      #2;
      n_checks++;
      if (busy_a !== 1'b1 || rddata_a[7:0] !== 8'h3C) begin
         n_fail++;
         $display("FAIL clear_write_same_edge: got busy %b data %h expected 1 3c", busy_a, rddata_a[7:0]);
      end
      n = 1;
      while (busy_a === 1'b1 && n <= 20) begin
         @(negedge CLK);
         write_a  = (n == 8);
         inaddr_a = 3'd6;
         in_a     = 8'h77;
         @(posedge CLK);
         #1;
         write_a = 1'b0;
         #2;
         n++;
      end
      n_checks++;
      if (rej_a !== 1'b1 || busy_a !== 1'b0 || n != 9) begin
         n_fail++;
         $display("FAIL clear_exit_edge_rej: got rej %b busy %b cycles %0d expected 1 0 8", rej_a, busy_a, n - 1);
      end
      mdl[6] = 8'h00;
      push_all("clear_write_result");
      drain_reads();
   endtask

   task automatic test_reset_mid_clear();
      do_write(3'd6, 8'h66);
      do_write(3'd7, 8'h77);
      push_all("midclr_load");
      drain_reads();
      @(negedge CLK);
      clear_a = 1'b1;
      @(posedge CLK);
      #1;
      clear_a = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      RESET_N = 1'b0;
      #1;
      n_checks++;
      if (busy_a !== 1'b0 || rej_a !== 1'b0) begin
         n_fail++;
         $display("FAIL midclr_reset_flags: got busy %b rej %b expected 0 0", busy_a, rej_a);
      end
      for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
      push_all("midclr_reset");
      drain_reads();
      @(negedge CLK);
      RESET_N = 1'b1;
      do_write(3'd5, 8'hAA);
      #2;
      n_checks++;
      if (busy_a !== 1'b0 || rej_a !== 1'b0) begin
         n_fail++;
         $display("FAIL midclr_post_write_flags: got busy %b rej %b expected 0 0", busy_a, rej_a);
      end
      push_all("midclr_post_write");
      drain_reads();
   endtask

   task automatic test_back_to_back();
      logic [2:0] a;
      logic [7:0] d;
      for (int i = 0; i < 12; i++) begin
         @(negedge CLK);
         a        = 3'($urandom_range(0, 7));
         d        = 8'($urandom);
         write_a  = 1'b1;
         inaddr_a = a;
         in_a     = d;
         mdl[a]   = d;
      end
      @(posedge CLK);
      #1;
      write_a = 1'b0;
      #2;
      n_checks++;
      if (rej_a !== 1'b0 || busy_a !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_flags: got rej %b busy %b expected 0 0", rej_a, busy_a);
      end
      push_all("b2b");
      drain_reads();
   endtask

   task automatic test_zero_reg();
      logic [15:0] pre;
      @(negedge CLK);
      write_z  = 1'b1;
      inaddr_z = 3'd0;
      in_z     = 16'hBEEF;
      rdaddr_z = {3'd0, 3'd0, 3'd0};
      #2;
      n_checks++;
      if (rddata_z !== 48'h0) begin
         n_fail++;
         $display("FAIL zero_reg_precommit: got %h expected 0", rddata_z);
      end
      @(posedge CLK);
      #1;
      write_z = 1'b0;
      #2;
      n_checks++;
      if (rddata_z !== 48'h0 || rej_z !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_reg_write0: got data %h rej %b expected 0 0", rddata_z, rej_z);
      end
      @(negedge CLK);
      write_z  = 1'b1;
      inaddr_z = 3'd7;
      in_z     = 16'hBEEF;
      rdaddr_z = {3'd7, 3'd0, 3'd7};
      #2;
      pre = BYP ? 16'hBEEF : 16'h0000;
      n_checks++;
      if (rddata_z[15:0] !== pre || rddata_z[31:16] !== 16'h0000) begin
         n_fail++;
         $display("FAIL zero_reg_addr7_precommit: got %h expected %h", rddata_z, {pre, 16'h0000, pre});
      end
      @(posedge CLK);
      #1;
      write_z = 1'b0;
      #2;
      n_checks++;
      if (rddata_z !== {16'hBEEF, 16'h0000, 16'hBEEF}) begin
         n_fail++;
         $display("FAIL zero_reg_addr7: got %h expected beef0000beef", rddata_z);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_negedge();
      test_clear();
      test_clear_and_write();
      test_reset_mid_clear();
      test_back_to_back();
      test_zero_reg();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
